// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// requester limit and the default watchdog length.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    localparam int UART_ARB_MAX_REQ     = 8;
    localparam int UART_ARB_DEF_TIMEOUT = 65536;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index found
// searching upward from last+1 and wrapping modulo N_REQ.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     any
);

    localparam int IDW = $clog2(N_REQ);

    logic [IDW-1:0] cand;

    // Walk the candidates from farthest to nearest so the nearest set bit wins.
    always_comb begin
        any    = |req;
        winner = '0;
        cand   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDW'((int'(last) + k) % N_REQ);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte writer among N_REQ requesters.
// Optional watchdog in WAIT enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = UART_ARB_DEF_TIMEOUT
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         req_ack,
    output logic [N_REQ-1:0]         req_done,
    input  logic                     tx_ready,
    input  logic                     tx_finish,
    output logic                     tx_send,
    output logic [7:0]               tx_data,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     err_timeout
);

    localparam int IDW    = $clog2(N_REQ);
    localparam int DATA_W = 8;

    arb_state_t     state, state_nxt;
    logic [IDW-1:0] last;
    logic [IDW-1:0] winner;
    logic           any;
    logic           grant_now;
    logic           finish_now;
    logic           wd_hit;

    uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req_valid),
        .last   (last),
        .winner (winner),
        .any    (any)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;

    assign wd_hit = (state == ST_WAIT) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter runs only in WAIT; a finish on the limit cycle wins over the flag.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == ST_SEND) begin
                wd_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_hit && !tx_finish) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign wd_hit      = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Next-state decode: arbitrate in IDLE, one-cycle SEND, WAIT until finish/timeout.
    always_comb begin
        state_nxt  = state;
        grant_now  = 1'b0;
        finish_now = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_ready && any) begin
                    grant_now = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_finish || wd_hit) begin
                    finish_now = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch owner and byte at the grant edge; report completion and rotate priority at the end.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            grant_id <= '0;
            tx_data  <= '0;
            last     <= IDW'(N_REQ - 1);
            req_done <= '0;
        end else begin
            req_done <= '0;
            if (grant_now) begin
                grant_id <= winner;
                tx_data  <= req_data[DATA_W*int'(winner) +: DATA_W];
            end
            if (finish_now) begin
                req_done <= N_REQ'(1) << grant_id;
                last     <= grant_id;
            end
        end
    end

    assign tx_send = (state == ST_SEND);
    assign req_ack = tx_send ? (N_REQ'(1) << grant_id) : '0;
    assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (default build, watchdog disabled): vector table,
// directed corner-case sequences and a randomized run against a reference model.
module tb_uart_tx_arbiter;

    logic        Clock;
    logic        Reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [3:0]  req_done;
    logic        tx_ready;
    logic        tx_finish;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic        err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_arbiter #(.N_REQ(4)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .req_done    (req_done),
        .tx_ready    (tx_ready),
        .tx_finish   (tx_finish),
        .tx_send     (tx_send),
        .tx_data     (tx_data),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [3:0] vld;
        logic       rdy;
        logic       fin;
        logic       snd;
        logic [3:0] ack;
        logic [3:0] done;
        logic       bsy;
        logic [1:0] gnt;
        logic [7:0] dat;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic [3:0] vld, input logic rdy, input logic fin,
                                input logic snd, input logic [3:0] ack, input logic [3:0] done,
                                input logic bsy, input logic [1:0] gnt, input logic [7:0] dat);
        vec_t v;
        v.vld = vld; v.rdy = rdy; v.fin = fin; v.snd = snd; v.ack = ack;
        v.done = done; v.bsy = bsy; v.gnt = gnt; v.dat = dat;
        return v;
    endfunction

    function automatic logic [63:0] obs();
        return 64'({err_timeout, tx_send, req_ack, req_done, busy, grant_id, tx_data});
    endfunction

    function automatic logic [63:0] pack_exp(input logic snd, input logic [3:0] ack,
                                             input logic [3:0] done, input logic bsy,
                                             input logic [1:0] gnt, input logic [7:0] dat);
        return 64'({1'b0, snd, ack, done, bsy, gnt, dat});
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset     = 1'b0;
        req_valid = 4'h0;
        tx_ready  = 1'b0;
        tx_finish = 1'b0;
        repeat (2) tick();
        Reset = 1'b1;
    endtask

    // Round-robin rule: first requester after 'last', wrapping; -1 if none.
    function automatic int rr_pick(input logic [3:0] v, input int lst);
        for (int k = 1; k <= 4; k++) begin
            int j;
            j = (lst + k) % 4;
            if (v[j[1:0]]) return j;
        end
        return -1;
    endfunction

    // Reference model state for the randomized run.
    logic [7:0] bytes[4];
    bit         drop_next[4];
    int         m_owner;
    int         m_last;
    int         m_wait;
    bit         m_in_send;
    logic       e_send;
    logic [3:0] e_ack;
    logic [3:0] e_done;
    logic       e_busy;
    logic [1:0] e_grant;
    logic [7:0] e_data;

    initial begin
        int bad;
        int w;
        logic [1:0] wi;

        Reset     = 1'b0;
        req_valid = 4'h0;
        req_data  = 32'h0;
        tx_ready  = 1'b0;
        tx_finish = 1'b0;

        // ---------------- Vector table: round-robin with all requests asserted
        tbl[0]  = mk(4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 8'h00);
        tbl[1]  = mk(4'hF, 1'b0, 1'b0, 1'b1, 4'h1, 4'h0, 1'b1, 2'd0, 8'h10);
        tbl[2]  = mk(4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 2'd0, 8'h10);
        tbl[3]  = mk(4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 2'd0, 8'h10);
        tbl[4]  = mk(4'hF, 1'b0, 1'b1, 1'b1, 4'h2, 4'h0, 1'b1, 2'd1, 8'h11);
        tbl[5]  = mk(4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd1, 8'h11);
        tbl[6]  = mk(4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 2'd1, 8'h11);
        tbl[7]  = mk(4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 4'h2, 1'b0, 2'd1, 8'h11);
        tbl[8]  = mk(4'hF, 1'b0, 1'b0, 1'b1, 4'h4, 4'h0, 1'b1, 2'd2, 8'h12);
        tbl[9]  = mk(4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 2'd2, 8'h12);
        tbl[10] = mk(4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 4'h4, 1'b0, 2'd2, 8'h12);
        tbl[11] = mk(4'hF, 1'b0, 1'b0, 1'b1, 4'h8, 4'h0, 1'b1, 2'd3, 8'h13);
        tbl[12] = mk(4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 2'd3, 8'h13);
        tbl[13] = mk(4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 4'h8, 1'b0, 2'd3, 8'h13);
        tbl[14] = mk(4'hF, 1'b0, 1'b0, 1'b1, 4'h1, 4'h0, 1'b1, 2'd0, 8'h10);
        tbl[15] = mk(4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 2'd0, 8'h10);
        tbl[16] = mk(4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 2'd0, 8'h10);
        tbl[17] = mk(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 8'h10);

        do_reset();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 18; k++) begin
            tick();
            chk($sformatf("table row %0d", k), obs(),
                pack_exp(tbl[k].snd, tbl[k].ack, tbl[k].done, tbl[k].bsy, tbl[k].gnt, tbl[k].dat));
            req_valid = tbl[k].vld;
            tx_ready  = tbl[k].rdy;
            tx_finish = tbl[k].fin;
        end

        // ---------------- Single request, byte A5 on requester 2
        do_reset();
        req_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
        req_valid = 4'b0100;
        tx_ready  = 1'b1;
        tick();
        chk("a5 send", obs(), pack_exp(1'b1, 4'h4, 4'h0, 1'b1, 2'd2, 8'hA5));
        req_valid = 4'h0;
        tx_ready  = 1'b0;
        tick();
        chk("a5 wait", obs(), pack_exp(1'b0, 4'h0, 4'h0, 1'b1, 2'd2, 8'hA5));
        tx_finish = 1'b1;
        tick();
        chk("a5 done", obs(), pack_exp(1'b0, 4'h0, 4'h4, 1'b0, 2'd2, 8'hA5));
        tx_finish = 1'b0;
        tick();
        chk("a5 done single pulse", obs(), pack_exp(1'b0, 4'h0, 4'h0, 1'b0, 2'd2, 8'hA5));

        // ---------------- tx_ready low holds off arbitration
        req_data  = {8'h00, 8'h00, 8'h00, 8'h5C};
        req_valid = 4'b0001;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (tx_send !== 1'b0 || req_ack !== 4'h0 || busy !== 1'b0) bad++;
        end
        chk("ready low hold cycles with activity", 64'(bad), 64'd0);
        tx_ready = 1'b1;
        tick();
        chk("ready rise send", obs(), pack_exp(1'b1, 4'h1, 4'h0, 1'b1, 2'd0, 8'h5C));
        req_valid = 4'h0;
        tx_ready  = 1'b0;
        tick();
        tx_finish = 1'b1;
        tick();
        chk("ready seq done", obs(), pack_exp(1'b0, 4'h0, 4'h1, 1'b0, 2'd0, 8'h5C));
        tx_finish = 1'b0;

        // ---------------- Reset during WAIT
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b0100;
        tx_ready  = 1'b1;
        tick();
        chk("rst seq send", obs(), pack_exp(1'b1, 4'h4, 4'h0, 1'b1, 2'd2, 8'h12));
        req_valid = 4'h0;
        tx_ready  = 1'b0;
        tick();
        Reset = 1'b0;
        tick();
        chk("reset in wait", obs(), pack_exp(1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 8'h00));
        Reset     = 1'b1;
        req_valid = 4'hF;
        tx_ready  = 1'b1;
        tx_finish = 1'b1;
        tick();
        chk("after reset grant 0", obs(), pack_exp(1'b1, 4'h1, 4'h0, 1'b1, 2'd0, 8'h10));
        req_valid = 4'h0;
        tx_ready  = 1'b0;
        tx_finish = 1'b0;
        tick();
        tx_finish = 1'b1;
        tick();
        tx_finish = 1'b0;

        // ---------------- Requester 1 holds valid through its own WAIT
        req_valid = 4'b0010;
        tx_ready  = 1'b1;
        tick();
        chk("hold seq send r1", obs(), pack_exp(1'b1, 4'h2, 4'h0, 1'b1, 2'd1, 8'h11));
        tx_ready = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (tx_send !== 1'b0 || req_ack !== 4'h0) bad++;
        end
        chk("hold seq no resend in wait", 64'(bad), 64'd0);
        tx_finish = 1'b1;
        tick();
        chk("hold seq done r1", obs(), pack_exp(1'b0, 4'h0, 4'h2, 1'b0, 2'd1, 8'h11));
        tx_finish = 1'b0;
        tx_ready  = 1'b1;
        tick();
        chk("hold seq r1 alone regranted", obs(), pack_exp(1'b1, 4'h2, 4'h0, 1'b1, 2'd1, 8'h11));
        req_valid = 4'b0011;
        tx_ready  = 1'b0;
        tick();
        tx_finish = 1'b1;
        tick();
        tx_finish = 1'b0;
        tx_ready  = 1'b1;
        tick();
        chk("hold seq other wins", obs(), pack_exp(1'b1, 4'h1, 4'h0, 1'b1, 2'd0, 8'h10));
        req_valid = 4'h0;
        tx_ready  = 1'b0;
        tick();
        tx_finish = 1'b1;
        tick();
        tx_finish = 1'b0;

        // ---------------- Randomized run against the reference model
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bytes[i]     = 8'h00;
            drop_next[i] = 1'b0;
        end
        req_data  = 32'h0;
        m_owner   = -1;
        m_last    = 3;
        m_wait    = 0;
        m_in_send = 1'b0;
        e_send    = 1'b0;
        e_ack     = 4'h0;
        e_done    = 4'h0;
        e_busy    = 1'b0;
        e_grant   = 2'd0;
        e_data    = 8'h00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            chk($sformatf("random cycle %0d", cyc), obs(),
                pack_exp(e_send, e_ack, e_done, e_busy, e_grant, e_data));

            for (int i = 0; i < 4; i++) begin
                if (drop_next[i]) begin
                    drop_next[i] = 1'b0;
                    if ($urandom_range(0, 1) == 0) begin
                        req_valid[i] = 1'b0;
                    end else begin
                        bytes[i] = 8'($urandom);
                    end
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    bytes[i]     = 8'($urandom);
                end
                if (e_ack[i]) drop_next[i] = 1'b1;
            end
            req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};

            tx_ready  = ($urandom_range(0, 3) != 0);
            tx_finish = 1'b0;
            if (m_owner >= 0 && m_in_send) begin
                tx_finish = ($urandom_range(0, 2) == 0);
            end else if (m_owner >= 0) begin
                if (m_wait == 0) tx_finish = 1'b1;
                else m_wait--;
            end

            e_send = 1'b0;
            e_ack  = 4'h0;
            e_done = 4'h0;
            if (m_owner < 0) begin
                w = rr_pick(req_valid, m_last);
                if (tx_ready && w >= 0) begin
                    wi        = w[1:0];
                    m_owner   = w;
                    m_in_send = 1'b1;
                    m_wait    = $urandom_range(0, 4);
                    e_send    = 1'b1;
                    e_ack     = 4'b0001 << wi;
                    e_grant   = wi;
                    e_data    = bytes[wi];
                end
            end else if (m_in_send) begin
                m_in_send = 1'b0;
            end else if (tx_finish) begin
                wi      = m_owner[1:0];
                e_done  = 4'b0001 << wi;
                m_last  = m_owner;
                m_owner = -1;
            end
            e_busy = (m_owner >= 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
